// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the scoreboarded register file.
// Latency: n/a (types only).
// Backpressure: n/a.
package reg_file_pkg;

    localparam int RF_WIDTH_DEF  = 32;
    localparam int RF_DEPTH_DEF  = 16;
    localparam int RF_ADDR_W_DEF = $clog2(RF_DEPTH_DEF);

    typedef logic [RF_ADDR_W_DEF-1:0] addr_t;
    typedef logic [RF_WIDTH_DEF-1:0]  word_t;

endpackage

// File: rtl/reg_file_sb_cell.sv
// One WIDTH-bit storage word with load enable and asynchronous clear.
// Latency: Q updates on the rising Clk edge after LE=1.
// Backpressure: none; a load is always accepted.
module reg_cell #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             LE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Hold the stored word unless loading.
    always_comb begin
        q_d = q_q;
        if (LE) begin
            q_d = D;
        end
    end

    // Storage flop, cleared immediately by Clr.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with 2 async read ports, 1 write port, per-register pending bits and a pending count.
// Latency: writes/reserves visible 1 cycle after the edge; with RF_BYPASS_EN a same-cycle write is forwarded to reads.
// Backpressure: none; every write and reserve is accepted (address-0 ones dropped when ZERO_R0=1).
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int WIDTH   = RF_WIDTH_DEF,
    parameter int DEPTH   = RF_DEPTH_DEF,
    parameter int ZERO_R0 = 1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              LE,
    input  logic [ADDR_W-1:0] WA,
    input  logic [WIDTH-1:0]  D,
    input  logic              RsvEn,
    input  logic [ADDR_W-1:0] RsvA,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic [WIDTH-1:0]  QA,
    output logic [WIDTH-1:0]  QB,
    output logic              PA,
    output logic              PB,
    output logic [ADDR_W:0]   PCnt
);

    logic [WIDTH-1:0] reg_q [DEPTH];
    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;
    logic [ADDR_W:0]  pcnt_q;
    logic [ADDR_W:0]  pcnt_d;
    logic             wr_vld;
    logic             rsv_vld;
    logic             pend_rise;
    logic             pend_fall;

    // Writes and reserves to register 0 are discarded when it is hardwired to zero.
    assign wr_vld  = LE    && !((ZERO_R0 != 0) && (WA   == '0));
    assign rsv_vld = RsvEn && !((ZERO_R0 != 0) && (RsvA == '0));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if ((gi == 0) && (ZERO_R0 != 0)) begin : g_zero
                assign reg_q[gi] = '0;
            end else begin : g_cell
                reg_cell #(.WIDTH(WIDTH)) u_cell (
                    .Clk (Clk),
                    .Clr (Clr),
                    .LE  (wr_vld && (WA == ADDR_W'(gi))),
                    .D   (D),
                    .Q   (reg_q[gi])
                );
            end
        end
    endgenerate

    // Next pending state: the retiring write clears, a reservation sets; the reservation
    // is applied last so a new producer on the same edge wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_vld) begin
            pending_d[WA] = 1'b0;
        end
        if (rsv_vld) begin
            pending_d[RsvA] = 1'b1;
        end
    end

    // At most one bit can rise (one reserve) and one fall (one write) per edge,
    // so the count moves by the difference of two single-bit events.
    always_comb begin
        pend_rise = |(pending_d & ~pending_q);
        pend_fall = |(pending_q & ~pending_d);
        pcnt_d    = pcnt_q + {{ADDR_W{1'b0}}, pend_rise} - {{ADDR_W{1'b0}}, pend_fall};
    end

    // Scoreboard state, cleared immediately by Clr.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            pending_q <= '0;
            pcnt_q    <= '0;
        end else begin
            pending_q <= pending_d;
            pcnt_q    <= pcnt_d;
        end
    end

    assign PCnt = pcnt_q;

    // Read muxes; with bypass, a write in flight this cycle shows its post-edge value.
    always_comb begin
        QA = reg_q[RA];
        QB = reg_q[RB];
        PA = pending_q[RA];
        PB = pending_q[RB];
`ifdef RF_BYPASS_EN
        if (wr_vld && !Clr && (RA == WA)) begin
            QA = D;
            PA = RsvEn && (RsvA == WA);
        end
        if (wr_vld && !Clr && (RB == WA)) begin
            QB = D;
            PB = RsvEn && (RsvA == WA);
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb (default parameters: WIDTH=32, DEPTH=16, ZERO_R0=1).
// Latency: checks sampled 1 ns after the rising edge or mid-cycle.
// Backpressure: n/a.
module tb_reg_file_sb;

    logic        Clk;
    logic        Clr;
    logic        LE;
    logic [3:0]  WA;
    logic [31:0] D;
    logic        RsvEn;
    logic [3:0]  RsvA;
    logic [3:0]  RA;
    logic [3:0]  RB;
    logic [31:0] QA;
    logic [31:0] QB;
    logic        PA;
    logic        PB;
    logic [4:0]  PCnt;

    int n_tests = 0;
    int n_fail  = 0;

    reg_file_sb dut (
        .Clk   (Clk),
        .Clr   (Clr),
        .LE    (LE),
        .WA    (WA),
        .D     (D),
        .RsvEn (RsvEn),
        .RsvA  (RsvA),
        .RA    (RA),
        .RB    (RB),
        .QA    (QA),
        .QB    (QB),
        .PA    (PA),
        .PB    (PB),
        .PCnt  (PCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        LE    = 1'b0;
        RsvEn = 1'b0;
    endtask

    initial begin
        Clr = 1'b1; LE = 1'b0; WA = '0; D = '0; RsvEn = 1'b0; RsvA = '0; RA = '0; RB = '0;
        #12;
        RA = 4'd5; RB = 4'd7;
        #1;
        chk("rst_qa",   QA,   32'h0);
        chk("rst_qb",   QB,   32'h0);
        chk("rst_pa",   {31'b0, PA}, 32'h0);
        chk("rst_pcnt", {27'b0, PCnt}, 32'h0);
        Clr = 1'b0;
        tick();

        // Write 5, check pre-edge (bypass-dependent) and post-edge.
        LE = 1'b1; WA = 4'd5; D = 32'haaaaffff; RA = 4'd5;
        #1;
`ifdef RF_BYPASS_EN
        chk("wr5_pre_qa", QA, 32'haaaaffff);
`else
        chk("wr5_pre_qa", QA, 32'h0);
`endif
        tick();
        idle();
        chk("wr5_post_qa", QA, 32'haaaaffff);

        // Reserve 3 then 7.
        RsvEn = 1'b1; RsvA = 4'd3;
        tick();
        chk("rsv3_pcnt", {27'b0, PCnt}, 32'd1);
        RsvA = 4'd7;
        tick();
        idle();
        chk("rsv7_pcnt", {27'b0, PCnt}, 32'd2);
        RA = 4'd3; RB = 4'd7;
        #1;
        chk("rsv3_pa", {31'b0, PA}, 32'd1);
        chk("rsv7_pb", {31'b0, PB}, 32'd1);

        // Retire 3.
        LE = 1'b1; WA = 4'd3; D = 32'h33333333;
        tick();
        idle();
        chk("ret3_pa",   {31'b0, PA}, 32'd0);
        chk("ret3_qa",   QA, 32'h33333333);
        chk("ret3_pcnt", {27'b0, PCnt}, 32'd1);

        // Same-edge write and reserve to 7: new producer wins.
        LE = 1'b1; WA = 4'd7; D = 32'h1234; RsvEn = 1'b1; RsvA = 4'd7;
        tick();
        idle();
        RA = 4'd7;
        #1;
        chk("same7_qa",   QA, 32'h1234);
        chk("same7_pa",   {31'b0, PA}, 32'd1);
        chk("same7_pcnt", {27'b0, PCnt}, 32'd1);

        // Write 7 and reserve 9 on one edge: independent, net count 0.
        LE = 1'b1; WA = 4'd7; D = 32'h5678; RsvEn = 1'b1; RsvA = 4'd9;
        tick();
        idle();
        RA = 4'd7; RB = 4'd9;
        #1;
        chk("diff_qa",   QA, 32'h5678);
        chk("diff_pa",   {31'b0, PA}, 32'd0);
        chk("diff_pb",   {31'b0, PB}, 32'd1);
        chk("diff_pcnt", {27'b0, PCnt}, 32'd1);

        // Register 0 is hardwired.
        LE = 1'b1; WA = 4'd0; D = 32'hffffffff; RsvEn = 1'b1; RsvA = 4'd0;
        tick();
        idle();
        RA = 4'd0;
        #1;
        chk("r0_qa",   QA, 32'h0);
        chk("r0_pa",   {31'b0, PA}, 32'd0);
        chk("r0_pcnt", {27'b0, PCnt}, 32'd1);

        // Mid-cycle 3 ns clear: effect visible before any clock edge.
        RA = 4'd5; RB = 4'd9;
        #2;
        Clr = 1'b1;
        #1;
        chk("clr_qa",   QA, 32'h0);
        chk("clr_pb",   {31'b0, PB}, 32'd0);
        chk("clr_pcnt", {27'b0, PCnt}, 32'd0);
        RB = 4'd7;
        #1;
        chk("clr_qb",   QB, 32'h0);
        #1;
        Clr = 1'b0;
        tick();
        chk("clr_hold_qa", QA, 32'h0);

        // Fill the scoreboard with all nonzero registers.
        RsvEn = 1'b1;
        for (int i = 1; i < 16; i++) begin
            RsvA = 4'(i);
            tick();
        end
        chk("full_pcnt", {27'b0, PCnt}, 32'd15);
        RsvA = 4'd4;
        tick();
        chk("rersv4_pcnt", {27'b0, PCnt}, 32'd15);
        RsvA = 4'd0;
        tick();
        idle();
        chk("rsv0_full_pcnt", {27'b0, PCnt}, 32'd15);
        LE = 1'b1; WA = 4'd2; D = 32'h22;
        tick();
        idle();
        chk("ret2_pcnt", {27'b0, PCnt}, 32'd14);
        #2;
        Clr = 1'b1;
        #1;
        chk("full_clr_pcnt", {27'b0, PCnt}, 32'd0);
        #1;
        Clr = 1'b0;
        tick();
        chk("post_clr_pcnt", {27'b0, PCnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
